// File: rtl/udp_input_arbiter_pkg.sv
// udp_input_arbiter_pkg: shared FSM encoding, counter width and helpers
// Exports: state_e (ARB/IN_HDR/IN_PKT), PKT_CNT_W, CTRL_BODY, rr_wrap()
package udp_input_arbiter_pkg;
   typedef enum logic [1:0] {ARB, IN_HDR, IN_PKT} state_e;
   localparam int PKT_CNT_W = 32;
   localparam int CTRL_BODY = 0;
   // (base + off) mod n for base < n and off < n, without a divider
   function automatic int rr_wrap(input int base, input int off, input int n);
      return (base + off >= n) ? base + off - n : base + off;
   endfunction
endpackage

// File: rtl/udp_input_arbiter_if.sv
// udp_input_arbiter_if: merged-stream bus, NUM_INPUTS inputs in, one stream out
// Signals: in_data/in_ctrl/in_wr/in_rdy (flattened per input), out_data/out_ctrl/out_wr/out_rdy
// Modports: master (stream source/sink side), slave (arbiter side)
interface udp_input_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8,
   parameter int NUM_INPUTS = 4
);
   logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
   logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_ctrl;
   logic [NUM_INPUTS-1:0]            in_wr;
   logic [NUM_INPUTS-1:0]            in_rdy;
   logic [DATA_WIDTH-1:0]            out_data;
   logic [CTRL_WIDTH-1:0]            out_ctrl;
   logic                             out_wr;
   logic                             out_rdy;
   modport master (output in_data, in_ctrl, in_wr, out_rdy, input in_rdy, out_data, out_ctrl, out_wr);
   modport slave (input in_data, in_ctrl, in_wr, out_rdy, output in_rdy, out_data, out_ctrl, out_wr);
endinterface

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small FIFO whose head word is visible on dout while !empty
// Ports: clk, reset (active-high sync), din/wr_en in, rd_en pops head, dout/empty/nearly_full out
module fallthrough_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             nearly_full,
   output logic             empty
);
   localparam int DEPTH = 1 << MAX_DEPTH_BITS;
   localparam int CNT_W = MAX_DEPTH_BITS + 1;
   logic [WIDTH-1:0]          mem_q [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]          depth_q;
   always_ff @(posedge clk)
      if (wr_en) mem_q[wr_ptr_q] <= din;
   always_ff @(posedge clk)
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         depth_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + MAX_DEPTH_BITS'(wr_en);
         rd_ptr_q <= rd_ptr_q + MAX_DEPTH_BITS'(rd_en);
         depth_q  <= depth_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   assign dout        = mem_q[rd_ptr_q];
   assign empty       = depth_q == '0;
   assign nearly_full = depth_q >= CNT_W'(DEPTH - 1);
endmodule

// File: rtl/udp_input_arbiter_rr_select.sv
// udp_input_arbiter_rr_select: first set request at or after start_i, wrapping at N
// Ports: req_i request vector, start_i search origin, idx_o winner, valid_o any request
module udp_input_arbiter_rr_select
   import udp_input_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] start_i,
   output logic [PW-1:0] idx_o,
   output logic          valid_o
);
   logic [PW-1:0] j;
   // Walk offsets downward so the smallest offset from start_i is the last to win
   always_comb begin
      idx_o = '0;
      j     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = PW'(rr_wrap(int'(start_i), k, N));
         if (req_i[j]) idx_o = j;
      end
   end
   assign valid_o = |req_i;
endmodule

// File: rtl/udp_input_arbiter.sv
// udp_input_arbiter: packet-granular round-robin merge of NUM_INPUTS streams into one
// Ports: clk, reset (active-low sync), bus (udp_input_arbiter_if.slave), pkt_count (32b per input)
// Optional: define UDP_INPUT_ARBITER_PKT_COUNT_EN to build the per-input packet counters
module udp_input_arbiter
   import udp_input_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH         = 64,
   parameter int CTRL_WIDTH         = DATA_WIDTH / 8,
   parameter int NUM_INPUTS         = 4,
   parameter int IN_FIFO_DEPTH_BITS = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   udp_input_arbiter_if.slave              bus,
   output logic [NUM_INPUTS*PKT_CNT_W-1:0] pkt_count
);
   localparam int PW = $clog2(NUM_INPUTS);
   state_e                state_q;
   logic [PW-1:0]         rr_ptr_q, grant_q, sel_idx;
   logic                  sel_valid, body, is_last;
   logic [NUM_INPUTS-1:0] empty, nearly_full, rd_en;
   logic [DATA_WIDTH-1:0] head_data [NUM_INPUTS];
   logic [CTRL_WIDTH-1:0] head_ctrl [NUM_INPUTS];
   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_fifo
      fallthrough_small_fifo #(
         .WIDTH(DATA_WIDTH + CTRL_WIDTH),
         .MAX_DEPTH_BITS(IN_FIFO_DEPTH_BITS)
      ) u_fifo (
         .clk(clk),
         .reset(~reset),
         .din({bus.in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH], bus.in_data[g*DATA_WIDTH +: DATA_WIDTH]}),
         .wr_en(bus.in_wr[g]),
         .rd_en(rd_en[g]),
         .dout({head_ctrl[g], head_data[g]}),
         .nearly_full(nearly_full[g]),
         .empty(empty[g])
      );
   end
   udp_input_arbiter_rr_select #(.N(NUM_INPUTS), .PW(PW)) u_sel (
      .req_i(~empty),
      .start_i(rr_ptr_q),
      .idx_o(sel_idx),
      .valid_o(sel_valid)
   );
   assign bus.in_rdy   = ~nearly_full;
   assign bus.out_data = head_data[grant_q];
   assign bus.out_ctrl = head_ctrl[grant_q];
   assign bus.out_wr   = state_q != ARB && !empty[grant_q] && bus.out_rdy;
   assign body         = bus.out_ctrl == CTRL_WIDTH'(CTRL_BODY);
   // First non-body word after a body word closes the packet
   assign is_last      = state_q == IN_PKT && bus.out_wr && !body;
   always_comb begin
      rd_en          = '0;
      rd_en[grant_q] = bus.out_wr;
   end
   always_ff @(posedge clk)
      if (!reset) begin
         state_q  <= ARB;
         rr_ptr_q <= '0;
         grant_q  <= '0;
      end else
         case (state_q)
            ARB: if (sel_valid) begin
               grant_q <= sel_idx;
               state_q <= IN_HDR;
            end
            IN_HDR: if (bus.out_wr && body) state_q <= IN_PKT;
            IN_PKT: if (is_last) begin
               state_q  <= ARB;
               rr_ptr_q <= grant_q == PW'(NUM_INPUTS - 1) ? '0 : grant_q + 1'b1;
            end
            default: state_q <= ARB;
         endcase
`ifdef UDP_INPUT_ARBITER_PKT_COUNT_EN
   logic [PKT_CNT_W-1:0] cnt_q [NUM_INPUTS];
   always_ff @(posedge clk)
      if (!reset) cnt_q <= '{default: '0};
      else if (is_last) cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
   always_comb
      for (int i = 0; i < NUM_INPUTS; i++) pkt_count[i*PKT_CNT_W +: PKT_CNT_W] = cnt_q[i];
`else
   assign pkt_count = '0;
`endif
endmodule

// File: tb/tb_udp_input_arbiter.sv
// tb_udp_input_arbiter: scoreboard bench for the round-robin packet arbiter
module tb_udp_input_arbiter;
   import udp_input_arbiter_pkg::*;
   localparam int N  = 4;
   localparam int DW = 64;
   localparam int CW = 8;
   logic          clk = 0;
   logic          reset = 0;
   logic [N*32-1:0] pkt_count;
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_fail = 0;
   logic [71:0]   exp_q [$];
   logic [71:0]   tx_q [N][$];
   int            obs_cyc [$];

   udp_input_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_INPUTS(N)) bus ();

   udp_input_arbiter #(
      .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_INPUTS(N), .IN_FIFO_DEPTH_BITS(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output scoreboard: every forwarded word must be the next expected one
   always @(negedge clk)
      if (reset && bus.out_wr) begin
         logic [71:0] e;
         obs_cyc.push_back(cyc);
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: unexpected word %h, expected none", {bus.out_ctrl, bus.out_data});
         end else begin
            e = exp_q.pop_front();
            if ({bus.out_ctrl, bus.out_data} !== e) begin
               n_fail++;
               $display("FAIL scoreboard: got %h, expected %h", {bus.out_ctrl, bus.out_data}, e);
            end
         end
      end

   function automatic logic [71:0] mk_word(input int port, input int id, input int idx, input logic [7:0] c);
      return {c, 8'(port), 8'(id), 8'(idx), 8'hA5, 32'($urandom)};
   endfunction

   function automatic bit tx_busy();
      for (int i = 0; i < N; i++) if (tx_q[i].size() > 0) return 1;
      return 0;
   endfunction

   // header FF, nbody words ctrl 0, last word ctrl 08
   task automatic queue_pkt(input int port, input int id, input int nbody);
      logic [71:0] w;
      for (int k = 0; k < nbody + 2; k++) begin
         w = mk_word(port, id, k, k == 0 ? 8'hFF : (k == nbody + 1 ? 8'h08 : 8'h00));
         tx_q[port].push_back(w);
         exp_q.push_back(w);
      end
   endtask

   // One clock: each input with queued words and in_rdy writes its next word
   task automatic cycle();
      logic [71:0] w;
      for (int i = 0; i < N; i++)
         if (tx_q[i].size() > 0 && bus.in_rdy[i]) begin
            w = tx_q[i].pop_front();
            bus.in_ctrl[i*CW +: CW] = w[71:64];
            bus.in_data[i*DW +: DW] = w[63:0];
            bus.in_wr[i] = 1'b1;
         end else
            bus.in_wr[i] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() > 0 || tx_busy()) && n < budget) begin
         cycle();
         n++;
      end
   endtask

   task automatic do_reset();
      reset = 0;
      bus.in_wr = '0;
      bus.out_rdy = 1;
      exp_q.delete();
      for (int i = 0; i < N; i++) tx_q[i].delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      obs_cyc.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp += 6;
      if (bus.out_wr !== 1'b0) begin n_fail++; $display("FAIL reset_out_wr: got %b, expected 0", bus.out_wr); end
      if (bus.in_rdy !== 4'hF) begin n_fail++; $display("FAIL reset_in_rdy: got %b, expected 1111", bus.in_rdy); end
      if (pkt_count !== '0) begin n_fail++; $display("FAIL reset_pkt_count: got %h, expected 0", pkt_count); end
      if (dut.state_q !== ARB) begin n_fail++; $display("FAIL reset_state: got %0d, expected ARB", dut.state_q); end
      if (dut.grant_q !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d, expected 0", dut.grant_q); end
      if (dut.rr_ptr_q !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d, expected 0", dut.rr_ptr_q); end
   endtask

   task automatic test_single();
      int t0;
      do_reset();
      queue_pkt(2, 1, 3);
      t0 = cyc;
      drain(50);
      n_cmp += 4;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d words left, expected 0", exp_q.size()); end
      if (obs_cyc.size() != 5) begin n_fail++; $display("FAIL single_count: got %0d words, expected 5", obs_cyc.size()); end
      if (dut.state_q !== ARB) begin n_fail++; $display("FAIL single_state: got %0d, expected ARB", dut.state_q); end
      if (dut.rr_ptr_q !== 2'd3) begin n_fail++; $display("FAIL single_rr_ptr: got %0d, expected 3", dut.rr_ptr_q); end
      if (obs_cyc.size() > 0) begin
         n_cmp++;
         if (obs_cyc[0] - t0 != 2) begin n_fail++; $display("FAIL single_latency: got %0d cycles, expected 2", obs_cyc[0] - t0); end
      end
   endtask

   task automatic test_all_inputs();
      do_reset();
      for (int p = 0; p < N; p++) queue_pkt(p, 10 + p, 1);
      drain(100);
      n_cmp += 2;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL all_drain: %0d words left, expected 0", exp_q.size()); end
      if (obs_cyc.size() != 12) begin n_fail++; $display("FAIL all_count: got %0d words, expected 12", obs_cyc.size()); end
      for (int k = 1; k < obs_cyc.size(); k++) begin
         n_cmp++;
         if (obs_cyc[k] - obs_cyc[k-1] != (k % 3 == 0 ? 2 : 1)) begin
            n_fail++;
            $display("FAIL all_gap[%0d]: got %0d, expected %0d", k, obs_cyc[k] - obs_cyc[k-1], k % 3 == 0 ? 2 : 1);
         end
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      do_reset();
      queue_pkt(1, 20, 4);
      while (exp_q.size() > 0 && n < 200) begin
         bus.out_rdy = ~bus.out_rdy;
         cycle();
         if (dut.state_q != ARB) begin
            n_cmp++;
            if (dut.grant_q !== 2'd1) begin n_fail++; $display("FAIL bp_grant: got %0d, expected 1", dut.grant_q); end
         end
         n++;
      end
      bus.out_rdy = 1;
      repeat (5) cycle();
      n_cmp += 2;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d words left, expected 0", exp_q.size()); end
      if (obs_cyc.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d words, expected 6", obs_cyc.size()); end
   endtask

   task automatic test_order();
      do_reset();
      queue_pkt(0, 30, 1);
      queue_pkt(3, 31, 1);
      queue_pkt(0, 32, 1);
      queue_pkt(0, 33, 1);
      drain(200);
      n_cmp += 2;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL order_drain: %0d words left, expected 0", exp_q.size()); end
      if (obs_cyc.size() != 12) begin n_fail++; $display("FAIL order_count: got %0d words, expected 12", obs_cyc.size()); end
   endtask

   task automatic test_pkt_count();
      logic [31:0] want [N];
`ifdef UDP_INPUT_ARBITER_PKT_COUNT_EN
      want = '{0, 5, 2, 0};
`else
      want = '{0, 0, 0, 0};
`endif
      do_reset();
      queue_pkt(1, 40, 1);
      queue_pkt(2, 41, 1);
      queue_pkt(1, 42, 1);
      queue_pkt(2, 43, 1);
      queue_pkt(1, 44, 1);
      queue_pkt(1, 45, 1);
      queue_pkt(1, 46, 1);
      drain(400);
      n_cmp++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL cnt_drain: %0d words left, expected 0", exp_q.size()); end
      for (int p = 0; p < N; p++) begin
         n_cmp++;
         if (pkt_count[p*32 +: 32] !== want[p]) begin
            n_fail++;
            $display("FAIL pkt_count[%0d]: got %0d, expected %0d", p, pkt_count[p*32 +: 32], want[p]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      do_reset();
      queue_pkt(1, 50, 6);
      while (obs_cyc.size() < 3 && n < 50) begin
         cycle();
         n++;
      end
      n_cmp++;
      if (obs_cyc.size() < 3) begin n_fail++; $display("FAIL mid_start: got %0d words, expected at least 3", obs_cyc.size()); end
      reset = 0;
      bus.in_wr = '0;
      exp_q.delete();
      tx_q[1].delete();
      repeat (3) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (bus.out_wr !== 1'b0) begin n_fail++; $display("FAIL mid_out_wr: got %b, expected 0", bus.out_wr); end
      end
      reset = 1;
      @(posedge clk);
      #1;
      n_cmp += 3;
      if (bus.in_rdy !== 4'hF) begin n_fail++; $display("FAIL mid_in_rdy: got %b, expected 1111", bus.in_rdy); end
      if (dut.state_q !== ARB) begin n_fail++; $display("FAIL mid_state: got %0d, expected ARB", dut.state_q); end
      if (pkt_count !== '0) begin n_fail++; $display("FAIL mid_pkt_count: got %h, expected 0", pkt_count); end
      obs_cyc.delete();
      queue_pkt(0, 51, 2);
      drain(60);
      n_cmp += 2;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_drain: %0d words left, expected 0", exp_q.size()); end
      if (obs_cyc.size() != 4) begin n_fail++; $display("FAIL mid_count: got %0d words, expected 4", obs_cyc.size()); end
   endtask

   initial begin
      bus.in_data = '0;
      bus.in_ctrl = '0;
      bus.in_wr = '0;
      bus.out_rdy = 1;
      test_reset();
      test_single();
      test_all_inputs();
      test_backpressure();
      test_order();
      test_pkt_count();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/udp_input_arbiter.md
Name: udp_input_arbiter

Overview:
- Packet-granular round-robin arbiter at the head of the user data path.
- Merges NUM_INPUTS NetFPGA-style packet streams (data/ctrl/wr/rdy) into one output stream for the downstream pipeline modules.
- Buffers each input in a small fall-through FIFO.
- Grants one input at a time and never interleaves words of different packets.

Parameters:
- DATA_WIDTH, 64, data word width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl word width.
- NUM_INPUTS, 4, number of input streams; 2..8.
- IN_FIFO_DEPTH_BITS, 2, log2 depth of each input FIFO.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset; block is in reset while reset==0.
- in_data  in  NUM_INPUTS*DATA_WIDTH  flattened input data; input i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- in_ctrl  in  NUM_INPUTS*CTRL_WIDTH  flattened input ctrl.
- in_wr  in  NUM_INPUTS  per-input write strobe.
- in_rdy  out  NUM_INPUTS  per-input ready; in_rdy[i] = !nearly_full of FIFO i.
- out_data  out  DATA_WIDTH  output data.
- out_ctrl  out  CTRL_WIDTH  output ctrl.
- out_wr  out  1  output write strobe.
- out_rdy  in  1  downstream ready.
- pkt_count  out  NUM_INPUTS*32  per-input forwarded-packet counters (optional feature).

Behaviour:
- Framing: a packet is one or more header words (ctrl!=0), then body words (ctrl==0). The first word with ctrl!=0 after a body word is the last word of the packet.
- Input FIFOs:
  - Fall-through FIFOs of depth 2^IN_FIFO_DEPTH_BITS.
  - Driven with active-high reset = !reset.
  - Writes while nearly_full are the sender's error; no overflow protection beyond in_rdy.
- FSM states (registered):
  - ARB → IN_HDR when any FIFO is non-empty. Grant goes to the first non-empty index searching from rr_ptr upward, modulo NUM_INPUTS. Exactly one cycle spent in ARB; out_wr=0 in ARB.
  - IN_HDR: on each forwarded word with ctrl==0 → IN_PKT.
  - IN_PKT: on a forwarded word with ctrl!=0 → ARB, and rr_ptr ← (grant+1) mod NUM_INPUTS.
- Forwarding:
  - In IN_HDR or IN_PKT, out_wr = !empty[grant] && out_rdy; fifo rd_en[grant] = out_wr.
  - out_data/out_ctrl are combinationally the head of FIFO grant.
- Stalls:
  - out_rdy=0 or granted FIFO empty holds state; grant is never released mid-packet.
  - Other inputs back up until their in_rdy deasserts.
- Latency: word written to an idle block at cycle t is at the FIFO head at t+1, grant registers at t+1, first out_wr is possible at t+2.
- Back-to-back: minimum one idle output cycle between packets (the ARB cycle).
- Fairness: all inputs continuously non-empty → grant order 0,1,…,NUM_INPUTS-1,0,…
- Single busy input: the same input is re-granted after each ARB cycle.
- rr_ptr width: log2(NUM_INPUTS), rounded up. Wrap from NUM_INPUTS-1 to 0 is explicit, not by overflow, so non-power-of-2 NUM_INPUTS works.
- Reset values (also when reset is asserted mid-packet):
  - state=ARB, rr_ptr=0, grant=0.
  - FIFOs flushed: in_rdy=all ones one cycle after reset deasserts.
  - out_wr=0, pkt_count=0.
  - A partially forwarded packet is truncated; downstream handles this.

Optional Feature:
- Macro: UDP_INPUT_ARBITER_PKT_COUNT_EN.
- Defined: pkt_count[i] increments by 1 on each last-word forward from input i, wrapping at 2^32.
- Not defined: pkt_count is tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package (udp_input_arbiter_pkg):
  - FSM state encoding (ARB, IN_HDR, IN_PKT).
  - Packet counter width 32.
  - Constant for ctrl==0 body-word check.
- One natural sub-module: rr_select. Combinational round-robin first-set search over a request vector from a start pointer; outputs index and valid.
- Input buffering reuses the existing fallthrough_small_fifo.

Test Plan:
- Reset, then single packet on input 2 (header ctrl=0xFF, 3 body words ctrl=0, last ctrl=0x08), out_rdy=1 → 5 words out in order; first out_wr 2 cycles after first in_wr; state returns to ARB; rr_ptr=3.
- All 4 inputs load one 3-word packet each simultaneously → output packet order 0,1,2,3; exactly one idle cycle between packets; no interleaving.
- Input 1 packet in flight, out_rdy toggled 1/0 every cycle → every word delivered exactly once, in order; grant stays 1 throughout.
- Input 0 streams 3 packets while input 3 has one pending → order 0,3,0,0.
- reset driven low mid-packet on input 1, then released → out_wr=0 during reset; in_rdy=4'b1111 after; next packet on input 0 forwards intact.
- With UDP_INPUT_ARBITER_PKT_COUNT_EN: 5 packets on input 1 and 2 on input 2 → pkt_count slices = {0,2,5,0}. Without the macro → all zero.
